// File: rtl/mem_access_unit.sv
// Load/store unit between a pipeline MEM stage and a word-wide data memory.
// Optional macro MEM_ACCESS_ALIGN_CHECK_EN turns misaligned halfword/word requests into errors.
module mem_access_unit #(
    parameter int MEM_WORDS = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    output logic        mem_we,
    input  logic [31:0] mem_rd
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    // Handshake: a request transfers on the rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE, and inputs are ignored until the unit returns there.
    state_t      state;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [1:0]  r_lane;
    logic [31:0] r_wdata;

    logic [31:0] req_index;
    logic        size_bad;
    logic        range_bad;
    logic        align_bad;
    logic        req_err;

    assign req_index = {2'b00, req_addr[31:2]};
    assign size_bad  = (req_size == 2'b11);
    assign range_bad = (req_index >= 32'(MEM_WORDS));
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    assign align_bad = ((req_size == 2'b01) && req_addr[0]) ||
                       ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign align_bad = 1'b0;
`endif
    assign req_err   = size_bad || range_bad || align_bad;
    assign req_ready = (state == IDLE);

    function automatic logic [31:0] merge_word(input logic [31:0] old_word,
                                               input logic [31:0] wdata,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane);
        logic [31:0] w;
        w = old_word;
        if (size == 2'b00) begin
            case (lane)
                2'd0: w[7:0]   = wdata[7:0];
                2'd1: w[15:8]  = wdata[7:0];
                2'd2: w[23:16] = wdata[7:0];
                default: w[31:24] = wdata[7:0];
            endcase
        end else if (size == 2'b01) begin
            // Halfwords force-align by ignoring addr[0].
            if (lane[1]) w[31:16] = wdata[15:0];
            else         w[15:0]  = wdata[15:0];
        end else begin
            w = wdata;
        end
        return w;
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [1:0]  size,
                                                input logic        sgn,
                                                input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0: b = word[7:0];
            2'd1: b = word[15:8];
            2'd2: b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        if (size == 2'b00)      r = {{24{sgn & b[7]}}, b};
        else if (size == 2'b01) r = {{16{sgn & h[15]}}, h};
        else                    r = word;
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            r_we       <= 1'b0;
            r_size     <= 2'b00;
            r_signed   <= 1'b0;
            r_lane     <= 2'b00;
            r_wdata    <= 32'd0;
            mem_a      <= 32'd0;
            mem_wd     <= 32'd0;
            mem_we     <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        r_we     <= req_we;
                        r_size   <= req_size;
                        r_signed <= req_signed;
                        r_lane   <= req_addr[1:0];
                        r_wdata  <= req_wdata;
                        if (req_err) begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'd0;
                        end else if (req_we && (req_size == 2'b10)) begin
                            state  <= WRITE;
                            mem_a  <= req_index;
                            mem_we <= 1'b1;
                            mem_wd <= req_wdata;
                        end else begin
                            // Loads and sub-word stores both need the current word first.
                            state <= READ;
                            mem_a <= req_index;
                        end
                    end
                end
                READ: begin
                    if (r_we) begin
                        state  <= WRITE;
                        mem_we <= 1'b1;
                        mem_wd <= merge_word(mem_rd, r_wdata, r_size, r_lane);
                    end else begin
                        state      <= DONE;
                        mem_a      <= 32'd0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= extend_load(mem_rd, r_size, r_signed, r_lane);
                    end
                end
                WRITE: begin
                    state      <= DONE;
                    mem_we     <= 1'b0;
                    mem_a      <= 32'd0;
                    mem_wd     <= 32'd0;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'd0;
                end
                DONE: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'd0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural word memory.
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    logic [31:0] mem [0:99];
    int          we_count;
    logic [31:0] last_we_a;
    int          resp_count;
    int          total;
    int          bad;

    mem_access_unit #(.MEM_WORDS(100)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd = (mem_a < 32'd100) ? mem[mem_a[6:0]] : 32'd0;

    always @(posedge clk) begin
        if (mem_we) begin
            if (mem_a < 32'd100) mem[mem_a[6:0]] <= mem_wd;
            we_count  = we_count + 1;
            last_we_a = mem_a;
        end
        if (resp_valid) resp_count = resp_count + 1;
    end

    // Issue one request from a negedge; returns latency (negedges after the accept edge
    // until resp_valid is seen, 99 on timeout) and pulse width. Ends on a negedge.
    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err,
                          output int lat, output int width);
        req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we = ~we; req_size = 2'b10; req_addr = 32'h0000_0010; req_wdata = 32'hFFFF_FFFF;
        lat = 99; width = 0; rdata = 32'hDEAD_BEEF; err = 1'bx;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = i; rdata = resp_rdata; err = resp_err; width = 1;
                break;
            end
        end
        if (lat != 99) begin
            @(negedge clk);
            if (resp_valid) width = 2;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
        total++; if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'd0) begin
            bad++; $display("FAIL reset_resp got=%b/%b/%h exp=0/0/0", resp_valid, resp_err, resp_rdata); end
        total++; if (mem_we !== 1'b0 || mem_a !== 32'd0 || mem_wd !== 32'd0) begin
            bad++; $display("FAIL reset_mem got=%b/%h/%h exp=0/0/0", mem_we, mem_a, mem_wd); end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_word();
        logic [31:0] rd; logic e; int lat, w, wc;
        wc = we_count;
        do_req(1'b1, 2'b10, 1'b0, 32'h8, 32'h1234_5678, rd, e, lat, w);
        total++; if (lat !== 2) begin bad++; $display("FAIL sw_latency got=%0d exp=2", lat); end
        total++; if (e !== 1'b0 || rd !== 32'd0) begin bad++; $display("FAIL sw_resp got=%b/%h exp=0/0", e, rd); end
        total++; if (we_count - wc !== 1 || last_we_a !== 32'd2) begin
            bad++; $display("FAIL sw_mem_we got=%0d@%h exp=1@2", we_count - wc, last_we_a); end
        total++; if (mem[2] !== 32'h1234_5678) begin bad++; $display("FAIL sw_word got=%h exp=12345678", mem[2]); end
        total++; if (w !== 1) begin bad++; $display("FAIL sw_pulse got=%0d exp=1", w); end
        do_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, rd, e, lat, w);
        total++; if (lat !== 2) begin bad++; $display("FAIL lw_latency got=%0d exp=2", lat); end
        total++; if (rd !== 32'h1234_5678 || e !== 1'b0) begin bad++; $display("FAIL lw_data got=%h/%b exp=12345678/0", rd, e); end
    endtask

    task automatic test_subword_store();
        logic [31:0] rd; logic e; int lat, w;
        do_req(1'b1, 2'b00, 1'b0, 32'h9, 32'hFFFF_FFAB, rd, e, lat, w);
        total++; if (lat !== 3) begin bad++; $display("FAIL sb_latency got=%0d exp=3", lat); end
        total++; if (mem[2] !== 32'h1234_AB78) begin bad++; $display("FAIL sb_merge got=%h exp=1234ab78", mem[2]); end
        do_req(1'b1, 2'b10, 1'b0, 32'h14, 32'hAAAA_AAAA, rd, e, lat, w);
        do_req(1'b1, 2'b01, 1'b0, 32'h16, 32'h0000_5555, rd, e, lat, w);
        total++; if (mem[5] !== 32'h5555_AAAA) begin bad++; $display("FAIL sh_merge got=%h exp=5555aaaa", mem[5]); end
        do_req(1'b1, 2'b00, 1'b0, 32'h17, 32'h0000_0011, rd, e, lat, w);
        total++; if (mem[5] !== 32'h1155_AAAA) begin bad++; $display("FAIL sb3_merge got=%h exp=1155aaaa", mem[5]); end
        do_req(1'b1, 2'b00, 1'b0, 32'h14, 32'h0000_0022, rd, e, lat, w);
        total++; if (mem[5] !== 32'h1155_AA22) begin bad++; $display("FAIL sb0_merge got=%h exp=1155aa22", mem[5]); end
    endtask

    task automatic test_load_ext();
        logic [31:0] rd; logic e; int lat, w;
        do_req(1'b0, 2'b00, 1'b1, 32'h9, 32'h0, rd, e, lat, w);
        total++; if (rd !== 32'hFFFF_FFAB) begin bad++; $display("FAIL lb_signed got=%h exp=ffffffab", rd); end
        do_req(1'b0, 2'b00, 1'b0, 32'h9, 32'h0, rd, e, lat, w);
        total++; if (rd !== 32'h0000_00AB) begin bad++; $display("FAIL lb_unsigned got=%h exp=000000ab", rd); end
        do_req(1'b0, 2'b01, 1'b1, 32'hA, 32'h0, rd, e, lat, w);
        total++; if (rd !== 32'h0000_1234) begin bad++; $display("FAIL lh_signed_hi got=%h exp=00001234", rd); end
        do_req(1'b0, 2'b01, 1'b1, 32'h8, 32'h0, rd, e, lat, w);
        total++; if (rd !== 32'hFFFF_AB78) begin bad++; $display("FAIL lh_signed_lo got=%h exp=ffffab78", rd); end
        do_req(1'b0, 2'b01, 1'b0, 32'h8, 32'h0, rd, e, lat, w);
        total++; if (rd !== 32'h0000_AB78) begin bad++; $display("FAIL lh_unsigned got=%h exp=0000ab78", rd); end
        do_req(1'b0, 2'b00, 1'b1, 32'hB, 32'h0, rd, e, lat, w);
        total++; if (rd !== 32'h0000_0012 || lat !== 2) begin bad++; $display("FAIL lb_lane3 got=%h/%0d exp=00000012/2", rd, lat); end
    endtask

    task automatic test_error();
        logic [31:0] rd; logic e; int lat, w, wc;
        wc = we_count;
        do_req(1'b0, 2'b10, 1'b0, 32'd400, 32'h0, rd, e, lat, w);
        total++; if (e !== 1'b1 || rd !== 32'd0 || lat !== 1) begin
            bad++; $display("FAIL err_range got=%b/%h/%0d exp=1/0/1", e, rd, lat); end
        do_req(1'b0, 2'b11, 1'b0, 32'h8, 32'h0, rd, e, lat, w);
        total++; if (e !== 1'b1 || rd !== 32'd0 || lat !== 1) begin
            bad++; $display("FAIL err_size got=%b/%h/%0d exp=1/0/1", e, rd, lat); end
        do_req(1'b1, 2'b10, 1'b0, 32'd400, 32'h5A5A_5A5A, rd, e, lat, w);
        total++; if (e !== 1'b1 || we_count !== wc) begin
            bad++; $display("FAIL err_store got=%b/%0d exp=1/0", e, we_count - wc); end
        total++; if (w !== 1) begin bad++; $display("FAIL err_pulse got=%0d exp=1", w); end
        do_req(1'b1, 2'b10, 1'b0, 32'd396, 32'h0BAD_CAFE, rd, e, lat, w);
        total++; if (e !== 1'b0 || lat !== 2 || mem[99] !== 32'h0BAD_CAFE) begin
            bad++; $display("FAIL last_word got=%b/%0d/%h exp=0/2/0badcafe", e, lat, mem[99]); end
    endtask

    task automatic test_misalign();
        logic [31:0] rd; logic e; int lat, w;
        do_req(1'b1, 2'b10, 1'b0, 32'h4, 32'hCAFE_F00D, rd, e, lat, w);
        do_req(1'b0, 2'b10, 1'b0, 32'h6, 32'h0, rd, e, lat, w);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        total++; if (e !== 1'b1 || rd !== 32'd0 || lat !== 1) begin
            bad++; $display("FAIL misalign_word got=%b/%h/%0d exp=1/0/1", e, rd, lat); end
`else
        total++; if (e !== 1'b0 || rd !== 32'hCAFE_F00D || lat !== 2) begin
            bad++; $display("FAIL misalign_word got=%b/%h/%0d exp=0/cafef00d/2", e, rd, lat); end
`endif
        do_req(1'b0, 2'b01, 1'b0, 32'h9, 32'h0, rd, e, lat, w);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        total++; if (e !== 1'b1 || rd !== 32'd0) begin
            bad++; $display("FAIL misalign_half got=%b/%h exp=1/0", e, rd); end
`else
        total++; if (e !== 1'b0 || rd !== 32'h0000_AB78) begin
            bad++; $display("FAIL misalign_half got=%b/%h exp=0/0000ab78", e, rd); end
`endif
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic e; int lat, w, wc, rc;
        wc = we_count; rc = resp_count;
        req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h9; req_wdata = 32'h0000_00EE; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        total++; if (mem_a !== 32'd2 || req_ready !== 1'b0) begin
            bad++; $display("FAIL mid_read got=%h/%b exp=2/0", mem_a, req_ready); end
        rst = 1'b1;
        #1;
        total++; if (req_ready !== 1'b1 || mem_a !== 32'd0 || mem_we !== 1'b0) begin
            bad++; $display("FAIL mid_reset got=%b/%h/%b exp=1/0/0", req_ready, mem_a, mem_we); end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk); @(negedge clk);
        total++; if (mem[2] !== 32'h1234_AB78 || we_count !== wc || resp_count !== rc) begin
            bad++; $display("FAIL mid_abandon got=%h/%0d/%0d exp=1234ab78/0/0", mem[2], we_count - wc, resp_count - rc); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b exp=1", req_ready); end
        do_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, rd, e, lat, w);
        total++; if (rd !== 32'h1234_AB78 || e !== 1'b0 || lat !== 2) begin
            bad++; $display("FAIL mid_next got=%h/%b/%0d exp=1234ab78/0/2", rd, e, lat); end
    endtask

    initial begin
        total = 0; bad = 0; we_count = 0; resp_count = 0; last_we_a = 32'd0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0;
        test_reset();
        test_word();
        test_subword_store();
        test_load_ext();
        test_error();
        test_misalign();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 100: number of 32-bit words in the attached data memory.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port req_valid, input, 1 bit: pipeline MEM-stage request present.
REQ-005 SHALL have port req_ready, output, 1 bit: unit accepts a request this cycle.
REQ-006 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-007 SHALL have port req_size, input, 2 bits: 00 byte, 01 halfword, 10 word, 11 reserved.
REQ-008 SHALL have port req_signed, input, 1 bit: sign-extend sub-word loads.
REQ-009 SHALL have port req_addr, input, 32 bits: byte address.
REQ-010 SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-011 SHALL have port resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata, output, 32 bits: extended load result; 0 for stores.
REQ-013 SHALL have port resp_err, output, 1 bit: qualified by resp_valid; request rejected.
REQ-014 SHALL have port mem_a, output, 32 bits: word index to memory, {2'b00, addr[31:2]}.
REQ-015 SHALL have port mem_wd, output, 32 bits: memory write data.
REQ-016 SHALL have port mem_we, output, 1 bit: memory write enable; memory writes at the rising clk edge.
REQ-017 SHALL have port mem_rd, input, 32 bits: combinational memory read data for mem_a.

Function
REQ-018 SHALL implement FSM states IDLE, READ, WRITE, DONE; req_ready = 1 only in IDLE.
REQ-019 SHALL accept a request at the rising edge where req_valid and req_ready are both 1, registering all req_* fields; later req_* changes are ignored until the next IDLE.
REQ-020 SHALL route acceptance as follows: error -> DONE; load -> READ; word store -> WRITE; byte or halfword store -> READ.
REQ-021 SHALL, in READ, drive mem_a and capture mem_rd at the cycle end; a load then goes to DONE, a sub-word store goes to WRITE.
REQ-022 SHALL, in WRITE, assert mem_we with mem_wd = merged word and go to DONE; mem_we SHALL be 0 in every other state.
REQ-023 SHALL merge little-endian: byte lane k = addr[1:0] occupies bits [8k+7:8k]; halfword lane = addr[1]; unselected bytes come from the captured word.
REQ-024 SHALL, in DONE, pulse resp_valid for exactly one cycle, then return to IDLE.
REQ-025 Latency from accept edge to resp_valid: 2 cycles for load and word store; 3 cycles for sub-word store; 1 cycle for error.
REQ-026 SHALL extend loads as follows: byte and halfword are zero-extended, or sign-extended when req_signed = 1; word is passed unchanged.
REQ-027 SHALL flag errors for req_size = 11 or for word index >= MEM_WORDS; an error request performs no memory access, with resp_rdata = 0 and resp_err = 1.
REQ-028 SHALL hold mem_a at the registered index in READ and WRITE, and at 0 in IDLE and DONE.

Reset
REQ-029 SHALL, when rst = 1, immediately force state IDLE, mem_we = 0, mem_a = 0, mem_wd = 0, resp_valid = 0, resp_rdata = 0, resp_err = 0; req_ready = 1.
REQ-030 SHALL, when reset occurs mid-operation, abandon the operation with no memory write and no response, so a memory word interrupted in READ is left unchanged.

Configuration
REQ-031 With macro MEM_ACCESS_ALIGN_CHECK_EN defined, a halfword with addr[0] = 1 or a word with addr[1:0] != 00 SHALL be an error per REQ-027.
REQ-032 Without MEM_ACCESS_ALIGN_CHECK_EN, misaligned requests SHALL be force-aligned: halfword ignores addr[0]; word ignores addr[1:0].

Verification
REQ-033 Store word 0x12345678 at addr 0x8, then load word from 0x8 -> mem_we pulse with mem_a = 2; load returns 0x12345678; resp_valid 2 cycles after each accept.
REQ-034 With word 2 = 0x12345678, store byte 0xAB at addr 0x9 -> word 2 becomes 0x1234AB78; resp_valid 3 cycles after accept.
REQ-035 With word 2 = 0x1234AB78, signed byte load at 0x9 -> 0xFFFFFFAB; unsigned -> 0x000000AB; signed halfword at 0xA -> 0x00001234.
REQ-036 Word load at addr 400 (index 100) or req_size = 11 -> resp_err = 1, resp_rdata = 0, no mem_we, resp_valid 1 cycle after accept.
REQ-037 Word load at 0x6 -> with the macro: resp_err = 1; without it: data from word 1.
REQ-038 Assert rst during READ of a byte store -> target word unchanged, no resp_valid; after release, req_ready = 1 and the next request completes normally.
